rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, legal 2..8.
REQ-002 Parameter W, default 8: ROM data width.
REQ-003 Parameter L, default 32: ROM depth; A = $clog2(L) is the address width.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  N  per-requester read request.
REQ-007 req_addr  in  N*A  per-requester address; requester i occupies bits [i*A +: A].
REQ-008 req_ready  out  N  one-hot accept pulse.
REQ-009 rsp_valid  out  N  one-hot response valid.
REQ-010 rsp_ready  in  N  per-requester response accept.
REQ-011 rsp_data  out  W  response data, shared by all requesters.
REQ-012 rom_addr  out  A  registered address to the synchronous ROM.
REQ-013 rom_data  in  W  ROM output, valid one cycle after rom_addr is sampled.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, CAPTURE and RESP.
REQ-015 IDLE: if any req_valid is set, grant g; pulse req_ready[g] for that cycle; register rom_addr <= req_addr[g] and latch g; go to ISSUE. Otherwise stay in IDLE.
REQ-016 ISSUE: hold rom_addr for one cycle while the ROM samples it; go to CAPTURE.
REQ-017 CAPTURE: register rsp_data <= rom_data, or 0 if the latched address >= L; go to RESP.
REQ-018 RESP: assert rsp_valid[g] and hold rsp_data stable until rsp_ready[g]=1; then go to IDLE.
REQ-019 Latency is 3 cycles from the req_ready pulse to the first rsp_valid cycle; with rsp_ready held high, the accept-to-accept throughput is 4 cycles.
REQ-020 req_ready SHALL be 0 in every state except IDLE; requests raised outside IDLE wait and are not dropped.
REQ-021 Round-robin grant: search from (last_grant+1) mod N upward with wrap-around; last_grant updates only when a grant is made.
REQ-022 A requester that deasserts req_valid before its grant SHALL never be served.
REQ-023 rsp_ready on non-granted lines SHALL be ignored.
REQ-024 rsp_valid SHALL be 0 outside RESP.
REQ-025 At most one bit of req_ready, and at most one bit of rsp_valid, SHALL be set in any cycle.

Reset
REQ-026 While rst=0 at posedge clk, set: state=IDLE, last_grant=N-1 (requester 0 wins first), rom_addr=0, rsp_data=0.
REQ-027 While rst=0, req_ready and rsp_valid SHALL be 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction; no response is issued for it after reset.

Configuration
REQ-029 With macro ROM_ARBITER_FIXED_PRIO_EN defined, the grant SHALL be fixed priority: the lowest index wins and last_grant is unused.
REQ-030 Without ROM_ARBITER_FIXED_PRIO_EN, the grant SHALL be round-robin as in REQ-021.

Structure
REQ-031 The shared package rom_arbiter_pkg SHALL hold the state enum typedef (IDLE, ISSUE, CAPTURE, RESP) and the default N/W/L constants.
REQ-032 Grant computation SHALL be a combinational sub-module rr_grant (inputs: request vector, last_grant; output: one-hot grant plus index).
REQ-033 The ROM itself is external: the bench instantiates block_rom and connects it to rom_addr/rom_data.

Verification
Setup: N=4, W=8, L=32, ROM initialised rom[i]=8'h10+i.
REQ-034 Single request: req_valid=4'b0100, addr2=5 -> req_ready=4'b0100, then rsp_valid=4'b0100 with rsp_data=8'h15 exactly 3 cycles later.
REQ-035 All four requesters held valid, addr i = i, rsp_ready=1 -> grants occur in order 0,1,2,3,0 with data 10,11,12,13,10 (hex); with ROM_ARBITER_FIXED_PRIO_EN defined, requester 0 is granted every time.
REQ-036 Backpressure: rsp_ready[1]=0 for 5 cycles in RESP -> rsp_valid[1] and rsp_data stay stable, and req_ready stays 0 throughout.
REQ-037 Boundary addresses: address 31 -> 8'h2F; L=20 with address 25 -> rsp_data=0.
REQ-038 Reset in ISSUE: drive rst=0 for one cycle -> no rsp_valid follows; the next request is granted to requester 0.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rom_arbiter_pkg
// Purpose : Shared types and default sizing for the ROM arbiter slice.
//           Holds the arbiter FSM state encoding and the default number of
//           requesters, ROM data width and ROM depth.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rom_arbiter_pkg;

  localparam int DEFAULT_N = 4;   // requesters
  localparam int DEFAULT_W = 8;   // ROM data width
  localparam int DEFAULT_L = 32;  // ROM depth

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/block_rom.sv
`default_nettype none
// ============================================================================
// Module  : block_rom
// Purpose : Synchronous ROM with one cycle of read latency. Contents are
//           rom[i] = 8'h10 + i (truncated to W bits).
// Ports   : clk  - clock
//           addr - read address (A)
//           data - registered read data (W)
// Revision: 1.0 - initial release
// ============================================================================
module block_rom #(
  parameter int W = 8,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic [A-1:0] addr,
  output logic [W-1:0] data
);

  always_ff @(posedge clk) begin
    data <= W'(32'h10 + 32'(addr));
  end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module  : rr_grant
// Purpose : Combinational grant selection for the ROM arbiter.
//           Default build: round-robin, searching upward from last_grant+1
//           with wrap-around. With ROM_ARBITER_FIXED_PRIO_EN defined the
//           lowest requesting index wins and last_grant is ignored.
// Ports   : req         - request vector (N)
//           last_grant  - index of the most recent grant
//           grant       - one-hot grant (N), all zero when nothing requests
//           grant_idx   - binary index of the granted requester
//           grant_valid - at least one requester is granted
// Revision: 1.0 - initial release
// ============================================================================
module rr_grant
  import rom_arbiter_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

`ifdef ROM_ARBITER_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Descending scan so the lowest requesting index is the last to write.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx   = IW'(i);
        grant_valid = 1'b1;
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end
`else
  always_comb begin
    int j;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    // Scan offsets N..1 from last_grant; the smallest offset (closest
    // requester after last_grant) writes last and therefore wins.
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_grant) + k) % N;
      if (req[j]) begin
        grant_idx   = IW'(j);
        grant_valid = 1'b1;
      end
    end
    grant = grant_valid ? (N'(1) << grant_idx) : '0;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rom_arbiter
// Purpose : Shares one external synchronous ROM between N requesters.
//           IDLE grants and registers the address, ISSUE lets the ROM sample
//           it, CAPTURE registers the ROM output (0 for out-of-range
//           addresses), RESP holds the response until the granted requester
//           accepts it.
//           Optional macro: ROM_ARBITER_FIXED_PRIO_EN selects fixed-priority
//           arbitration (lowest index wins) instead of round-robin.
// Ports   : clk       - clock
//           rst       - synchronous reset, active low
//           req_valid - per-requester read request (N)
//           req_addr  - per-requester address, requester i at [i*A +: A]
//           req_ready - one-hot accept pulse (N)
//           rsp_valid - one-hot response valid (N)
//           rsp_ready - per-requester response accept (N)
//           rsp_data  - shared response data (W)
//           rom_addr  - registered ROM address (A)
//           rom_data  - ROM output, valid one cycle after rom_addr sampled
// Revision: 1.0 - initial release
// ============================================================================
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  parameter  int W  = DEFAULT_W,
  parameter  int L  = DEFAULT_L,
  localparam int A  = $clog2(L),
  localparam int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*A-1:0] req_addr,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic [A-1:0]   rom_addr,
  input  logic [W-1:0]   rom_data
);

  state_e        state_q,      state_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] gnt_idx_q,    gnt_idx_d;
  logic [A-1:0]  rom_addr_q,   rom_addr_d;
  logic [W-1:0]  rsp_data_q,   rsp_data_d;
  logic [N-1:0]  rsp_valid_q,  rsp_valid_d;

  logic [N-1:0]  grant_oh;
  logic [IW-1:0] grant_idx;
  logic          grant_valid;
  logic [A-1:0]  sel_addr;
  logic          addr_in_range;

  rr_grant #(.N(N)) u_rr_grant (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_addr      = req_addr[int'(grant_idx)*A +: A];
  // The address register is untouched until the next IDLE grant, so it still
  // holds the latched address during CAPTURE.
  assign addr_in_range = (32'(rom_addr_q) < L);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_idx_d    = gnt_idx_q;
    rom_addr_d   = rom_addr_q;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          // Accept pulse is gated by reset so nothing is accepted while
          // the reset is being applied.
          req_ready    = rst ? grant_oh : '0;
          rom_addr_d   = sel_addr;
          gnt_idx_d    = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d  = addr_in_range ? rom_data : '0;
        rsp_valid_d = N'(1) << gnt_idx_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[gnt_idx_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(N - 1);
      gnt_idx_q    <= '0;
      rom_addr_q   <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_idx_q    <= gnt_idx_d;
      rom_addr_q   <= rom_addr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  // Response valid is forced low for the whole reset cycle, including the
  // cycle in which reset is first driven low.
  assign rsp_valid = rsp_valid_q & {N{rst}};
  assign rsp_data  = rsp_data_q;
  assign rom_addr  = rom_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rom_arbiter
// Purpose : Directed self-checking bench for rom_arbiter (N=4, W=8, L=32)
//           plus a second instance with L=20 for the out-of-range address.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int A = 5;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*A-1:0] req_addr;
  logic [W-1:0]   rsp_data, rom_data;
  logic [A-1:0]   rom_addr;

  logic [N-1:0]   s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic [N*A-1:0] s_req_addr;
  logic [W-1:0]   s_rsp_data, s_rom_data;
  logic [A-1:0]   s_rom_addr;

  int checks = 0;
  int errors = 0;

`ifdef ROM_ARBITER_FIXED_PRIO_EN
  int exp_g [5] = '{0, 0, 0, 0, 0};
`else
  int exp_g [5] = '{0, 1, 2, 3, 0};
`endif

  rom_arbiter #(.N(N), .W(W), .L(32)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );
  block_rom #(.W(W), .A(A)) u_rom (.clk(clk), .addr(rom_addr), .data(rom_data));

  rom_arbiter #(.N(N), .W(W), .L(20)) u_dut20 (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_addr(s_req_addr), .req_ready(s_req_ready),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .rom_addr(s_rom_addr), .rom_data(s_rom_data)
  );
  block_rom #(.W(W), .A(A)) u_rom20 (.clk(clk), .addr(s_rom_addr), .data(s_rom_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst         = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    rsp_ready   = '0;
    s_req_valid = '0;
    s_req_addr  = '0;
    s_rsp_ready = '0;

    // Reset: requests during reset are not accepted.
    next(); req_valid = 4'hF; #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rom_addr",  32'(rom_addr),  32'h0);
    next(); rst = 1'b1; req_valid = '0; #1;
    chk("idle_no_req", 32'(req_ready), 32'h0);

    // All four valid, addr i = i, rsp_ready high: 4-cycle accept spacing.
    req_addr  = {5'd3, 5'd2, 5'd1, 5'd0};
    rsp_ready = 4'hF;
    for (int k = 0; k < 5; k++) begin
      next(); req_valid = 4'hF; #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << exp_g[k]));
      next(); #1;
      chk("rr_issue_rdy", 32'(req_ready), 32'h0);
      next(); #1;
      chk("rr_capture_vld", 32'(rsp_valid), 32'h0);
      next(); #1;
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << exp_g[k]));
      chk("rr_rsp_data",  32'(rsp_data),  32'(8'h10 + exp_g[k]));
    end
    next(); req_valid = '0; rsp_ready = '0; #1;
    chk("rr_done_vld", 32'(rsp_valid), 32'h0);

    // Single request: requester 2, address 5 -> 8'h15 three cycles later.
    next(); req_valid = 4'b0100; req_addr = {5'd0, 5'd5, 5'd0, 5'd0}; #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    next(); req_valid = '0; #1;
    chk("single_rom_addr", 32'(rom_addr), 32'd5);
    chk("single_issue_vld", 32'(rsp_valid), 32'h0);
    next(); #1;
    chk("single_cap_vld", 32'(rsp_valid), 32'h0);
    next(); #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("single_rsp_data",  32'(rsp_data),  32'h15);
    rsp_ready = 4'b1011;  // non-granted lines only
    next(); #1;
    chk("ignore_other_rdy", 32'(rsp_valid), 32'h4);
    rsp_ready = 4'b0100;
    next(); rsp_ready = '0; #1;
    chk("single_released", 32'(rsp_valid), 32'h0);

    // Requester 1 at address 31 with 5 cycles of backpressure. Requester 0
    // pulses a request mid-transaction and withdraws it; requester 3 waits.
    next(); req_valid = 4'b0010; req_addr = {5'd7, 5'd0, 5'd31, 5'd0}; #1;
    chk("bp_ready", 32'(req_ready), 32'h2);
    next(); req_valid = 4'b1001; #1;
    chk("bp_issue_rdy", 32'(req_ready), 32'h0);
    next(); req_valid = 4'b1000; #1;
    chk("bp_capture_rdy", 32'(req_ready), 32'h0);
    rsp_ready = 4'b1101;
    for (int j = 0; j < 5; j++) begin
      next(); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("bp_rsp_data",  32'(rsp_data),  32'h2F);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 4'b0010;
    next(); rsp_ready = '0; #1;
    chk("wait_granted", 32'(req_ready), 32'h8);
    chk("wait_rsp_off", 32'(rsp_valid), 32'h0);
    next(); req_valid = '0; #1;
    chk("wait_rom_addr", 32'(rom_addr), 32'd7);
    next(); #1;
    next(); #1;
    chk("wait_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("wait_rsp_data",  32'(rsp_data),  32'h17);
    rsp_ready = 4'b1000;
    next(); rsp_ready = '0; #1;

    // Reset during ISSUE abandons the transaction.
    next(); req_valid = 4'b0100; req_addr = {5'd0, 5'd9, 5'd0, 5'd0}; #1;
    chk("rstiss_ready", 32'(req_ready), 32'h4);
    next(); req_valid = '0; rst = 1'b0; #1;
    chk("rstiss_rdy_low", 32'(req_ready), 32'h0);
    next(); rst = 1'b1; #1;
    chk("rstiss_rom_addr", 32'(rom_addr), 32'h0);
    for (int j = 0; j < 4; j++) begin
      next(); #1;
      chk("rstiss_no_rsp", 32'(rsp_valid), 32'h0);
    end
    next(); req_valid = 4'hF; #1;
    chk("rstiss_first_g0", 32'(req_ready), 32'h1);
    next(); req_valid = '0; #1;

    // L=20 instance: address 25 is out of range, 19 is the last valid one.
    next(); s_req_valid = 4'b0001; s_req_addr = {5'd0, 5'd0, 5'd0, 5'd25}; #1;
    chk("l20_ready", 32'(s_req_ready), 32'h1);
    next(); s_req_valid = '0; #1;
    next(); #1;
    next(); #1;
    chk("l20_oor_valid", 32'(s_rsp_valid), 32'h1);
    chk("l20_oor_data",  32'(s_rsp_data),  32'h0);
    s_rsp_ready = 4'b0001;
    next(); s_rsp_ready = '0; s_req_valid = 4'b0001; s_req_addr = {5'd0, 5'd0, 5'd0, 5'd19}; #1;
    chk("l20_ready2", 32'(s_req_ready), 32'h1);
    next(); s_req_valid = '0; #1;
    next(); #1;
    next(); #1;
    chk("l20_last_valid", 32'(s_rsp_valid), 32'h1);
    chk("l20_last_data",  32'(s_rsp_data),  32'h23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
